// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and window-index helper for the 5x5 window generator.
package conv_pkg;

    localparam int KSIZE = 5;
    localparam int KTAPS = KSIZE * KSIZE;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int win_idx(input int r, input int c);
        return r * KSIZE + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-row delay line: dout is the sample written DEPTH enabled cycles earlier.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 28
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pure storage, deliberately unreset; consumers never look at stale rows.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator: four chained line buffers plus a 5x5 register window.
// Optional macro CONV_WIN_POS_EN adds out_row/out_col (window top-left coordinate).
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    output logic [KTAPS*DATA_WIDTH-1:0]   data_25P,
    output logic                          frame_done
`ifdef CONV_WIN_POS_EN
    ,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          last_col, last_row, emit, done;

    logic [DATA_WIDTH-1:0] lb_out [4];
    logic [DATA_WIDTH-1:0] new_col [KSIZE];
    logic [DATA_WIDTH-1:0] win_q [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] win_d [KSIZE][KSIZE];

    logic [KTAPS*DATA_WIDTH-1:0] data_d, data_q;
    logic                        out_valid_q, frame_done_q;

    // A start-of-frame pixel is (0,0) regardless of where the counters were.
    assign cur_col  = in_sof ? '0 : col_q;
    assign cur_row  = in_sof ? '0 : row_q;
    assign last_col = (cur_col == CW'(IMG_WIDTH - 1));
    assign last_row = (cur_row == RW'(IMG_HEIGHT - 1));

    assign emit = in_valid && !in_sof && (state_q == STREAM) && (col_q >= CW'(KSIZE - 1));
    assign done = emit && last_row && last_col;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            if (in_sof) begin
                state_d = FILL;
            end else begin
                case (state_q)
                    FILL:    if (last_col && cur_row == RW'(KSIZE - 2)) state_d = STREAM;
                    STREAM:  if (last_col && last_row) state_d = FILL;
                    default: state_d = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
        .clk(clk), .en(in_valid), .din(in_data),   .dout(lb_out[0]));
    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk(clk), .en(in_valid), .din(lb_out[0]), .dout(lb_out[1]));
    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
        .clk(clk), .en(in_valid), .din(lb_out[1]), .dout(lb_out[2]));
    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb3 (
        .clk(clk), .en(in_valid), .din(lb_out[2]), .dout(lb_out[3]));

    // Row 0 of the window is the oldest line, so the deepest buffer feeds it.
    assign new_col[0] = lb_out[3];
    assign new_col[1] = lb_out[2];
    assign new_col[2] = lb_out[1];
    assign new_col[3] = lb_out[0];
    assign new_col[4] = in_data;

    always_comb begin
        data_d = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][KSIZE-1] = new_col[r];
        end
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                data_d[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= '0;
        end else begin
            out_valid_q  <= emit;
            frame_done_q <= done;
            if (emit) begin
                data_q <= data_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign data_25P   = data_q;

`ifdef CONV_WIN_POS_EN
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (emit) begin
            out_row_q <= cur_row - RW'(KSIZE - 1);
            out_col_q <= cur_col - CW'(KSIZE - 1);
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

endmodule
